thiele_ext_service_hub: RTL and testbench

THIELE_EXT_SERVICE_HUB -- requirements
Module: thiele_ext_service_hub

---
 rtl/thiele_ext_service_hub.sv | 215 +++++++++++++++++++++
 tb/tb_thiele_ext_service_hub.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thiele_ext_service_hub.sv
// -----------------------------------------------------------------------------
// thiele_ext_service_hub
//
// Shares one external service backend between NUM_CH requesters (for example
// the logic engine and the Python executor). One transaction is in flight at a
// time. Requesters are granted round-robin, and every accepted request ends
// with exactly one ch_ack pulse. That pulse carries either the backend data or,
// if the backend stalls for TIMEOUT cycles, ERR_DATA with ch_err set.
//
// Ports
//   clk, rst_n      : clock (rising edge); synchronous active-low reset
//   ch_req          : per-channel request level, held until ch_ack
//   ch_addr         : per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_ack          : one-cycle completion pulse, one-hot or zero
//   ch_data, ch_err : response data / timeout flag, held until the next response
//   svc_valid       : request to backend
//   svc_ch          : index of the granted channel
//   svc_addr        : address latched at grant time
//   svc_ready       : backend accepts the request
//   svc_rvalid      : backend response strobe
//   svc_rdata       : backend response data
//   busy            : high whenever the FSM is not IDLE
//   timeout_cnt     : saturating count of timed-out transactions
//   o_dbg_state     : current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module thiele_ext_service_hub #(
  parameter int                NUM_CH   = 2,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [DATA_W-1:0]          ch_data,
  output logic                       ch_err,
  output logic                       svc_valid,
  output logic [$clog2(NUM_CH)-1:0]  svc_ch,
  output logic [ADDR_W-1:0]          svc_addr,
  input  logic                       svc_ready,
  input  logic                       svc_rvalid,
  input  logic [DATA_W-1:0]          svc_rdata,
  output logic                       busy,
  output logic [15:0]                timeout_cnt,
  output logic [1:0]                 o_dbg_state
);

  localparam int CH_W = $clog2(NUM_CH);
  // The timer has to be able to hold TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 2);
  // The timer holds k in the k-th ISSUE/WAIT cycle, counting from 0. The cycle
  // with timer == TIMEOUT-1 is the last cycle in which the transaction can
  // still finish normally.
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_ack;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;
  logic                r_valid;
  logic [CH_W-1:0]     r_ch;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_busy;
  logic [15:0]         r_tcnt;
  logic [TW-1:0]       r_timer;
  logic [CH_W-1:0]     r_last;

  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   w_ack_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_err_nxt;
  logic                w_valid_nxt;
  logic [CH_W-1:0]     w_ch_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [15:0]         w_tcnt_nxt;
  logic [TW-1:0]       w_timer_nxt;
  logic [CH_W-1:0]     w_last_nxt;

  logic                w_grant_vld;
  logic [CH_W-1:0]     w_grant_idx;
  logic [CH_W-1:0]     w_cand;
  logic                w_expire;
  logic [15:0]         w_tcnt_inc;

  // Round-robin search. It starts one past the last granted channel, so after
  // reset (r_last = NUM_CH-1) channel 0 has first priority.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = CH_W'((int'(r_last) + k) % NUM_CH);
      if (!w_grant_vld && ch_req[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_expire   = (TIMEOUT != 0) && (r_timer >= T_LAST);
  assign w_tcnt_inc = (r_tcnt == 16'hFFFF) ? r_tcnt : r_tcnt + 16'd1;

  // Backend handshake. svc_valid rises in ISSUE with svc_ch and svc_addr
  // already latched. All three stay stable until a cycle with svc_valid &&
  // svc_ready, after which svc_valid is low from the next cycle on. Exactly
  // one svc_rvalid is expected per accepted request, and only in WAIT. A
  // strobe in any other state belongs to no live transaction and is dropped.
  // In ISSUE, an acceptance in the expiry cycle takes priority over the
  // timeout, because the backend has already committed to the request.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_valid_nxt = r_valid;
    w_ch_nxt    = r_ch;
    w_addr_nxt  = r_addr;
    w_tcnt_nxt  = r_tcnt;
    w_timer_nxt = r_timer;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = ST_ISSUE;
          w_ch_nxt    = w_grant_idx;
          w_addr_nxt  = ch_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
          w_valid_nxt = 1'b1;
          w_timer_nxt = '0;
        end
      end
      ST_ISSUE: begin
        w_timer_nxt = r_timer + 1'b1;
        if (svc_ready) begin
          w_state_nxt = ST_WAIT;
          w_valid_nxt = 1'b0;
        end else if (w_expire) begin
          w_state_nxt = ST_RESP;
          w_valid_nxt = 1'b0;
          w_data_nxt  = ERR_DATA;
          w_err_nxt   = 1'b1;
          w_tcnt_nxt  = w_tcnt_inc;
        end
      end
      ST_WAIT: begin
        w_timer_nxt = r_timer + 1'b1;
        // A response in the expiry cycle beats the timeout.
        if (svc_rvalid) begin
          w_state_nxt = ST_RESP;
          w_data_nxt  = svc_rdata;
          w_err_nxt   = 1'b0;
        end else if (w_expire) begin
          w_state_nxt = ST_RESP;
          w_data_nxt  = ERR_DATA;
          w_err_nxt   = 1'b1;
          w_tcnt_nxt  = w_tcnt_inc;
        end
      end
      ST_RESP: begin
        w_ack_nxt[r_ch] = 1'b1;
        w_last_nxt      = r_ch;
        w_state_nxt     = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_tcnt  <= '0;
      r_timer <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
      r_valid <= w_valid_nxt;
      r_ch    <= w_ch_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_tcnt  <= w_tcnt_nxt;
      r_timer <= w_timer_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign ch_ack      = r_ack;
  assign ch_data     = r_data;
  assign ch_err      = r_err;
  assign svc_valid   = r_valid;
  assign svc_ch      = r_ch;
  assign svc_addr    = r_addr;
  assign busy        = r_busy;
  assign timeout_cnt = r_tcnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_thiele_ext_service_hub.sv
// -----------------------------------------------------------------------------
// tb_thiele_ext_service_hub
//
// Bench for thiele_ext_service_hub with NUM_CH=2, TIMEOUT=8 and
// ERR_DATA=32'hDEADBEEF. A second instance with TIMEOUT=0 covers the mode in
// which the timeout is disabled.
//
// Timing reference: cycle 0 is the first cycle in which svc_valid is high.
// The bench drives svc_ready in cycle dr and svc_rvalid in cycle
// r = dr+1+dv. The request completes normally when r <= TIMEOUT-1, and ch_ack
// then arrives in cycle r+2. Otherwise the timeout fires and ch_ack arrives in
// cycle TIMEOUT+1.
// -----------------------------------------------------------------------------
module tb_thiele_ext_service_hub;

  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [1:0]  ch_req;
  logic [63:0] ch_addr;
  logic [1:0]  ch_ack;
  logic [31:0] ch_data;
  logic        ch_err;
  logic        svc_valid;
  logic [0:0]  svc_ch;
  logic [31:0] svc_addr;
  logic        svc_ready;
  logic        svc_rvalid;
  logic [31:0] svc_rdata;
  logic        busy;
  logic [15:0] timeout_cnt;
  logic [1:0]  dbg_state;

  // ---------------- no-timeout DUT signals ----------------
  logic [1:0]  nt_req;
  logic [63:0] nt_addr;
  logic [1:0]  nt_ack;
  logic [31:0] nt_data;
  logic        nt_err;
  logic        nt_valid;
  logic [0:0]  nt_ch;
  logic [31:0] nt_svc_addr;
  logic        nt_ready;
  logic        nt_rvalid;
  logic [31:0] nt_rdata;
  logic        nt_busy;
  logic [15:0] nt_tcnt;
  logic [1:0]  nt_dbg;

  thiele_ext_service_hub #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO),
                           .ERR_DATA(ERRD)) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_ack(ch_ack), .ch_data(ch_data), .ch_err(ch_err),
    .svc_valid(svc_valid), .svc_ch(svc_ch), .svc_addr(svc_addr),
    .svc_ready(svc_ready), .svc_rvalid(svc_rvalid), .svc_rdata(svc_rdata),
    .busy(busy), .timeout_cnt(timeout_cnt), .o_dbg_state(dbg_state)
  );

  thiele_ext_service_hub #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(0),
                           .ERR_DATA(ERRD)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .ch_req(nt_req), .ch_addr(nt_addr),
    .ch_ack(nt_ack), .ch_data(nt_data), .ch_err(nt_err),
    .svc_valid(nt_valid), .svc_ch(nt_ch), .svc_addr(nt_svc_addr),
    .svc_ready(nt_ready), .svc_rvalid(nt_rvalid), .svc_rdata(nt_rdata),
    .busy(nt_busy), .timeout_cnt(nt_tcnt), .o_dbg_state(nt_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  // {channel, err, data} for each ack still owed by the DUT
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ch_ack !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_ack: got %b want 00 (t=%0t)", ch_ack, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_vec", ch_ack, mon_e[33] ? 2'b10 : 2'b01);
        check("ack_err", ch_err, mon_e[32]);
        check("ack_data", ch_data, mon_e[31:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Raises the requests in 'raise' and waits for the grant. It then plays the
  // backend (ready in cycle dr, rvalid in cycle dr+1+dv) and checks the grant,
  // the ISSUE-phase stability and the ack latency. When other requesters are
  // still pending at the ack, the task returns at once so the next grant can
  // follow.
  task automatic run_txn(input logic [1:0] raise, input logic exp_ch, input bit drop_others,
                         input int dr, input int dv, input logic [31:0] rdata,
                         input logic exp_err, input logic [31:0] exp_data,
                         input int exp_lat, input logic [15:0] exp_tcnt);
    logic [31:0] exp_addr;
    int wait_n;
    int lim;
    bit got_ack;
    bit stop;
    exp_addr = ch_addr[exp_ch*32 +: 32];
    lim = (dr < TO - 1) ? dr : TO - 1;
    ch_req = ch_req | raise;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (svc_valid !== 1'b1 && wait_n < 20);
    if (svc_valid !== 1'b1) begin
      n_total++;
      n_bad++;
      $display("FAIL grant_timeout: got svc_valid=%b want 1", svc_valid);
      ch_req = 2'b00;
      return;
    end
    check("grant_lat", wait_n, 1);
    check("svc_ch", svc_ch, exp_ch);
    check("svc_addr", svc_addr, exp_addr);
    check("busy_on", busy, 1'b1);
    exp_q.push_back({exp_ch, exp_err, exp_data});
    if (drop_others) ch_req = ch_req & (exp_ch ? 2'b10 : 2'b01);
    got_ack = 1'b0;
    stop = 1'b0;
    for (int c = 0; c < 16 && !stop; c++) begin
      if (c > 0) @(negedge clk);
      if (!got_ack) begin
        check("svc_valid", svc_valid, (c <= lim) ? 1'b1 : 1'b0);
        if (c <= lim) begin
          check("issue_ch_stable", svc_ch, exp_ch);
          check("issue_addr_stable", svc_addr, exp_addr);
        end
      end
      if (!got_ack && ch_ack[exp_ch] === 1'b1) begin
        got_ack = 1'b1;
        check("ack_lat", c, exp_lat);
        ch_req[exp_ch] = 1'b0;
        if (ch_req != 2'b00) stop = 1'b1;
      end
      svc_ready  = (c == dr);
      svc_rvalid = (c == dr + 1 + dv);
      svc_rdata  = (c == dr + 1 + dv) ? rdata : $urandom;
    end
    svc_ready  = 1'b0;
    svc_rvalid = 1'b0;
    if (!got_ack) begin
      n_total++;
      n_bad++;
      $display("FAIL ack_missing: got none want ch%0d", exp_ch);
    end else if (!stop) begin
      check("data_hold", ch_data, exp_data);
      check("err_hold", ch_err, exp_err);
      check("busy_off", busy, 1'b0);
    end
    check("timeout_cnt", timeout_cnt, exp_tcnt);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        ch;
    logic [31:0] addr;
    int          dr;
    int          dv;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    logic [15:0] exp_tcnt;
  } vec_t;

  vec_t vecs[7];

  // ---------------- reference model state ----------------
  logic        m_last;
  logic [15:0] m_tcnt;

  initial begin
    logic [1:0]  mask;
    logic        pick;
    int          dr, dv, r, lat;
    bit          ok;
    logic [31:0] rd;
    bit          flag;

    vecs[0] = '{1'b0, 32'h40,   0, 0,  32'hABCD1234, 1'b0, 32'hABCD1234, 3, 16'd0};
    vecs[1] = '{1'b1, 32'h1000, 0, 99, 32'h0,        1'b1, ERRD,         9, 16'd1};
    vecs[2] = '{1'b0, 32'h80,   0, 6,  32'h12345678, 1'b0, 32'h12345678, 9, 16'd1};
    vecs[3] = '{1'b1, 32'h84,   0, 7,  32'h55,       1'b1, ERRD,         9, 16'd2};
    vecs[4] = '{1'b0, 32'hC0,   5, 0,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 8, 16'd2};
    vecs[5] = '{1'b1, 32'h44,   99, 0, 32'h1,        1'b1, ERRD,         9, 16'd3};
    vecs[6] = '{1'b0, 32'h200,  2, 3,  32'h0BADF00D, 1'b0, 32'h0BADF00D, 8, 16'd3};

    rst_n = 1'b0;
    ch_req = '0; ch_addr = '0; svc_ready = 1'b0; svc_rvalid = 1'b0; svc_rdata = '0;
    nt_req = '0; nt_addr = '0; nt_ready = 1'b0; nt_rvalid = 1'b0; nt_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ch_ack, 2'b00);
    check("rst_data", ch_data, 32'h0);
    check("rst_err", ch_err, 1'b0);
    check("rst_valid", svc_valid, 1'b0);
    check("rst_ch", svc_ch, 1'b0);
    check("rst_addr", svc_addr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_tcnt", timeout_cnt, 16'h0);
    rst_n = 1'b1;

    // Round robin: both channels held, each re-raised after its ack.
    ch_addr = {32'h0000_0B00, 32'h0000_0A00};
    run_txn(2'b11, 1'b0, 1'b0, 0, 0, 32'h1111_0000, 1'b0, 32'h1111_0000, 3, 16'd0);
    run_txn(2'b11, 1'b1, 1'b0, 0, 0, 32'h2222_0001, 1'b0, 32'h2222_0001, 3, 16'd0);
    run_txn(2'b11, 1'b0, 1'b0, 0, 0, 32'h3333_0000, 1'b0, 32'h3333_0000, 3, 16'd0);
    run_txn(2'b11, 1'b1, 1'b0, 0, 0, 32'h4444_0001, 1'b0, 32'h4444_0001, 3, 16'd0);
    ch_req = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // Table of directed single-requester transactions.
    for (int i = 0; i < 7; i++) begin
      ch_addr[vecs[i].ch*32 +: 32] = vecs[i].addr;
      run_txn(vecs[i].ch ? 2'b10 : 2'b01, vecs[i].ch, 1'b1, vecs[i].dr, vecs[i].dv,
              vecs[i].rdata, vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_lat,
              vecs[i].exp_tcnt);
    end
    m_last = vecs[6].ch;
    m_tcnt = vecs[6].exp_tcnt;

    // Randomized transactions checked against the arbitration/timeout model.
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      pick = (mask == 2'b11) ? ~m_last : mask[1];
      dr = $urandom_range(0, 9);
      if (dr == TO - 1) dr = TO;
      dv = $urandom_range(0, 7);
      r  = dr + 1 + dv;
      ok = (r <= TO - 1);
      rd = $urandom;
      lat = ok ? r + 2 : TO + 1;
      if (!ok) m_tcnt = m_tcnt + 16'd1;
      ch_addr = {32'($urandom), 32'($urandom)};
      run_txn(mask, pick, 1'b1, dr, dv, rd, !ok, ok ? rd : ERRD, lat, m_tcnt);
      m_last = pick;
    end

    // Reset while waiting for the backend, followed by a late response.
    ch_addr[31:0] = 32'h1234;
    ch_req = 2'b01;
    flag = 1'b0;
    for (int k = 0; k < 20 && !flag; k++) begin
      @(negedge clk);
      flag = (svc_valid === 1'b1);
    end
    check("rstw_grant", flag, 1'b1);
    svc_ready = 1'b1;
    @(negedge clk);
    svc_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    ch_req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_data", ch_data, 32'h0);
    check("rstw_err", ch_err, 1'b0);
    check("rstw_valid", svc_valid, 1'b0);
    check("rstw_addr", svc_addr, 32'h0);
    check("rstw_ch", svc_ch, 1'b0);
    check("rstw_tcnt", timeout_cnt, 16'h0);
    svc_rvalid = 1'b1;
    svc_rdata = 32'h9999_9999;
    @(negedge clk);
    svc_rvalid = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ch_ack !== 2'b00 || busy !== 1'b0 || ch_data !== 32'h0) flag = 1'b1;
    end
    check("rstw_quiet", flag, 1'b0);
    // Priority returns to channel 0 after reset.
    ch_addr = {32'h0000_0F10, 32'h0000_0F00};
    run_txn(2'b11, 1'b0, 1'b1, 1, 1, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 5, 16'd0);

    // TIMEOUT=0: a stalled backend never produces an error.
    nt_addr[31:0] = 32'h55;
    nt_req = 2'b01;
    flag = 1'b0;
    for (int k = 0; k < 20 && !flag; k++) begin
      @(negedge clk);
      flag = (nt_valid === 1'b1);
    end
    check("nt_grant", flag, 1'b1);
    flag = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (nt_valid !== 1'b1 || nt_svc_addr !== 32'h55 || nt_ch !== 1'b0 || nt_ack !== 2'b00)
        flag = 1'b1;
    end
    check("nt_hold", flag, 1'b0);
    nt_ready = 1'b1;
    @(negedge clk);
    nt_ready = 1'b0;
    nt_req = 2'b00;
    nt_rvalid = 1'b1;
    nt_rdata = 32'h77;
    @(negedge clk);
    nt_rvalid = 1'b0;
    @(negedge clk);
    check("nt_ack", nt_ack, 2'b01);
    check("nt_data", nt_data, 32'h77);
    check("nt_err", nt_err, 1'b0);
    check("nt_tcnt", nt_tcnt, 16'h0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
